startup_pattern_datapath: RTL and testbench
===========================================

STARTUP_PATTERN_DATAPATH -- requirements
Module: startup_pattern_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NPAT, default 8: number of startup display patterns, range 1..31.
REQ-003 Parameter PAT_WIDTH, default 8: display pattern width in bits.
REQ-004 Parameter PATTERNS, default walking-one (entry i = 1 << i): flat vector of NPAT*PAT_WIDTH bits, entry i at bits [i*PAT_WIDTH +: PAT_WIDTH].
REQ-005 CLK  input  1: system clock, all registers rising-edge.
REQ-006 RST_N  input  1: asynchronous active-low reset.
REQ-007 CLEAR  input  1: synchronous clear of address and pattern registers.
REQ-008 DISP  input  1: display enable, gates LEDS.
REQ-009 LOAD_PAT  input  1: load the addressed pattern into the pattern register.
REQ-010 NXT_ADR  input  1: advance the pattern address.
REQ-011 RST_TIMER  input  1: hold the timer at zero.
REQ-012 TIMER  output  16: free-running dwell timer, consumed by the display FSM.
REQ-013 DONE  output  1: high when all patterns have been addressed.
REQ-014 ADR  output  5: current pattern address, for debug.
REQ-015 LEDS  output  PAT_WIDTH: registered display pattern.

Function
REQ-016 Timer: RST_TIMER=1 -> TIMER<=0 at the next edge; RST_TIMER=0 -> TIMER<=TIMER+1, saturating at 16'hFFFF with no wrap.
REQ-017 Address: CLEAR=1 -> ADR<=0; else NXT_ADR=1 and ADR<NPAT -> ADR<=ADR+1; NXT_ADR at ADR=NPAT -> ADR holds.
REQ-018 DONE SHALL be 1 exactly when ADR==NPAT and SHALL change in the same cycle ADR does; it SHALL be 0 after CLEAR.
REQ-019 Pattern: CLEAR=1 -> PAT<=0; else LOAD_PAT=1 and ADR in 1..NPAT -> PAT<=PATTERNS entry ADR-1; LOAD_PAT at ADR=0 is ignored.
REQ-020 CLEAR SHALL take priority over NXT_ADR and LOAD_PAT in the same cycle.
REQ-021 NXT_ADR and LOAD_PAT in the same cycle: LOAD_PAT uses the pre-increment ADR.
REQ-022 LEDS SHALL be registered: LEDS<=DISP ? PAT_next : 0, where PAT_next is the value PAT takes at the same edge; one-cycle latency from DISP to LEDS.
REQ-023 Register triplication: TIMER, ADR, PAT and LEDS SHALL each be held in three copies.
REQ-024 Each copy's next-state logic SHALL use the bitwise 2-of-3 majority of the three copies.
REQ-025 Every output SHALL be the 2-of-3 majority of its copies.
REQ-026 A single upset in any one copy SHALL never reach an output and SHALL be scrubbed at the next edge.
REQ-027 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 RST_N=0 SHALL asynchronously set all copies to: TIMER=0, ADR=0, DONE=0, PAT=0, LEDS=0.
REQ-029 Release of RST_N SHALL be glitch-free: the first edge after release uses normal REQ-016..022 behaviour.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence with no residual state.

Verification
REQ-031 RST_TIMER=0 for 3000 cycles -> TIMER=3000 (16'hBB8); hold RST_TIMER=0 for 70000 cycles -> TIMER=16'hFFFF, held; RST_TIMER=1 -> TIMER=0 next edge.
REQ-032 Default parameters, DISP=1, pulse sequence (NXT_ADR, then LOAD_PAT two cycles later) x8 -> LEDS=01,02,04,...,80; DONE=1 after the 8th NXT_ADR; a 9th NXT_ADR leaves ADR=8.
REQ-033 Drive CLEAR, NXT_ADR and LOAD_PAT together at ADR=3 -> ADR=0, PAT=0, LEDS=0, DONE=0.
REQ-034 PAT=8'h10, toggle DISP 1->0->1 -> LEDS=10,00,10, each one cycle after the DISP change.
REQ-035 Force one copy of ADR and one copy of TIMER to an arbitrary value -> ADR, TIMER and DONE outputs are unchanged, and the copies reconverge after one edge.
REQ-036 Assert RST_N=0 asynchronously at ADR=5 between clock edges -> all outputs are 0 immediately, with no wait for a clock edge.

Source files
------------

// File: rtl/startup_pattern_datapath.sv
// Startup display pattern datapath: dwell timer, pattern address counter,
// pattern register and registered LED drive. Every state register is kept
// in three copies; each copy reloads from the bitwise 2-of-3 vote, so a
// single upset is masked at the outputs and scrubbed at the next edge.

package startup_pattern_pkg;
    // Walking-one table: entry i = 1 << i, packed entry i at [i*w +: w].
    function automatic logic [4095:0] walk_one(input int npat, input int w);
        logic [4095:0] v;
        v = '0;
        for (int i = 0; i < npat; i++) begin
            if (i < w) v[i*w + i] = 1'b1;
        end
        return v;
    endfunction
endpackage

module startup_pattern_datapath #(
    parameter int NPAT      = 8,
    parameter int PAT_WIDTH = 8,
    parameter logic [NPAT*PAT_WIDTH-1:0] PATTERNS =
        (NPAT*PAT_WIDTH)'(startup_pattern_pkg::walk_one(NPAT, PAT_WIDTH))
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLEAR,
    input  logic                 DISP,
    input  logic                 LOAD_PAT,
    input  logic                 NXT_ADR,
    input  logic                 RST_TIMER,
    output logic [15:0]          TIMER,
    output logic                 DONE,
    output logic [4:0]           ADR,
    output logic [PAT_WIDTH-1:0] LEDS
);

    localparam logic [4:0] NPAT_A = 5'(NPAT);

    // Three copies of each register
    logic [15:0]          timer_q0, timer_q1, timer_q2;
    logic [4:0]           adr_q0, adr_q1, adr_q2;
    logic [PAT_WIDTH-1:0] pat_q0, pat_q1, pat_q2;
    logic [PAT_WIDTH-1:0] leds_q0, leds_q1, leds_q2;

    // Voted values and next state
    logic [15:0]          timer_v, timer_n;
    logic [4:0]           adr_v, adr_n;
    logic [PAT_WIDTH-1:0] pat_v, pat_n;
    logic [PAT_WIDTH-1:0] leds_v, leds_n;

    assign timer_v = (timer_q0 & timer_q1) | (timer_q0 & timer_q2) | (timer_q1 & timer_q2);
    assign adr_v   = (adr_q0 & adr_q1)     | (adr_q0 & adr_q2)     | (adr_q1 & adr_q2);
    assign pat_v   = (pat_q0 & pat_q1)     | (pat_q0 & pat_q2)     | (pat_q1 & pat_q2);
    assign leds_v  = (leds_q0 & leds_q1)   | (leds_q0 & leds_q2)   | (leds_q1 & leds_q2);

    // Outputs come only from voted registers: no input-to-output path
    assign TIMER = timer_v;
    assign ADR   = adr_v;
    assign DONE  = (adr_v == NPAT_A);
    assign LEDS  = leds_v;

    // Next-state from voted values; CLEAR beats NXT_ADR/LOAD_PAT, and
    // LOAD_PAT indexes with the pre-increment address
    always_comb begin
        timer_n = timer_v;
        adr_n   = adr_v;
        pat_n   = pat_v;
        if (RST_TIMER)
            timer_n = '0;
        else if (timer_v != 16'hFFFF)
            timer_n = timer_v + 16'd1;
        if (CLEAR) begin
            adr_n = '0;
            pat_n = '0;
        end else begin
            if (NXT_ADR && (adr_v < NPAT_A))
                adr_n = adr_v + 5'd1;
            if (LOAD_PAT && (adr_v != 5'd0) && (adr_v <= NPAT_A))
                pat_n = PATTERNS[(int'(adr_v) - 1) * PAT_WIDTH +: PAT_WIDTH];
        end
        leds_n = DISP ? pat_n : '0;
    end

    // All copies load the same voted next state, which scrubs any upset copy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer_q0 <= '0; timer_q1 <= '0; timer_q2 <= '0;
            adr_q0   <= '0; adr_q1   <= '0; adr_q2   <= '0;
            pat_q0   <= '0; pat_q1   <= '0; pat_q2   <= '0;
            leds_q0  <= '0; leds_q1  <= '0; leds_q2  <= '0;
        end else begin
            timer_q0 <= timer_n; timer_q1 <= timer_n; timer_q2 <= timer_n;
            adr_q0   <= adr_n;   adr_q1   <= adr_n;   adr_q2   <= adr_n;
            pat_q0   <= pat_n;   pat_q1   <= pat_n;   pat_q2   <= pat_n;
            leds_q0  <= leds_n;  leds_q1  <= leds_n;  leds_q2  <= leds_n;
        end
    end

endmodule

// File: tb/tb_startup_pattern_datapath.sv
// Directed bench for startup_pattern_datapath with default parameters.
module tb_startup_pattern_datapath;

    logic        CLK = 1'b0;
    logic        RST_N, CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TIMER;
    logic [15:0] TIMER;
    logic        DONE;
    logic [4:0]  ADR;
    logic [7:0]  LEDS;

    int vectors = 0;
    int miscompares = 0;

    startup_pattern_datapath dut (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .DISP(DISP),
        .LOAD_PAT(LOAD_PAT), .NXT_ADR(NXT_ADR), .RST_TIMER(RST_TIMER),
        .TIMER(TIMER), .DONE(DONE), .ADR(ADR), .LEDS(LEDS)
    );

    always #5 CLK = ~CLK;

    // One clock; inputs change and outputs are sampled at the falling edge
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CLEAR = 0; DISP = 0; LOAD_PAT = 0; NXT_ADR = 0; RST_TIMER = 1;
        cyc();
        vectors++;
        if ({TIMER, ADR, DONE, LEDS} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset: got timer=%h adr=%h done=%b leds=%h want all 0", TIMER, ADR, DONE, LEDS);
        end
        RST_N = 1'b1;
        cyc();
    endtask

    task automatic test_timer();
        RST_TIMER = 1'b1; cyc();
        RST_TIMER = 1'b0;
        repeat (3000) cyc();
        vectors++;
        if (TIMER !== 16'h0BB8) begin
            miscompares++; $display("FAIL timer_3000: got %h want 0bb8", TIMER);
        end
        repeat (70000) cyc();
        vectors++;
        if (TIMER !== 16'hFFFF) begin
            miscompares++; $display("FAIL timer_sat: got %h want ffff", TIMER);
        end
        cyc();
        vectors++;
        if (TIMER !== 16'hFFFF) begin
            miscompares++; $display("FAIL timer_hold: got %h want ffff", TIMER);
        end
        RST_TIMER = 1'b1; cyc();
        vectors++;
        if (TIMER !== 16'h0000) begin
            miscompares++; $display("FAIL timer_clear: got %h want 0000", TIMER);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] exp_leds;
        DISP = 1'b1;
        CLEAR = 1'b1; cyc(); CLEAR = 1'b0;
        // Load at ADR=0 must be ignored
        LOAD_PAT = 1'b1; cyc(); LOAD_PAT = 1'b0;
        vectors++;
        if (LEDS !== 8'h00) begin
            miscompares++; $display("FAIL load_at_0: got %h want 00", LEDS);
        end
        for (int k = 0; k < 8; k++) begin
            NXT_ADR = 1'b1; cyc(); NXT_ADR = 1'b0;
            vectors++;
            if (ADR !== 5'(k + 1) || DONE !== (k == 7)) begin
                miscompares++;
                $display("FAIL seq_adr[%0d]: got adr=%0d done=%b want adr=%0d done=%b", k, ADR, DONE, k + 1, (k == 7));
            end
            cyc();
            LOAD_PAT = 1'b1; cyc(); LOAD_PAT = 1'b0;
            exp_leds = 8'h01 << k;
            vectors++;
            if (LEDS !== exp_leds) begin
                miscompares++; $display("FAIL seq_leds[%0d]: got %h want %h", k, LEDS, exp_leds);
            end
        end
        NXT_ADR = 1'b1; cyc(); NXT_ADR = 1'b0;
        vectors++;
        if (ADR !== 5'd8 || DONE !== 1'b1) begin
            miscompares++; $display("FAIL seq_ninth: got adr=%0d done=%b want 8 1", ADR, DONE);
        end
    endtask

    task automatic test_load_with_next();
        CLEAR = 1'b1; cyc(); CLEAR = 1'b0;
        NXT_ADR = 1'b1; cyc(); cyc();
        // ADR=2: combined pulse loads entry 1 (8'h02) then advances to 3
        LOAD_PAT = 1'b1; cyc(); LOAD_PAT = 1'b0; NXT_ADR = 1'b0;
        vectors++;
        if (ADR !== 5'd3 || LEDS !== 8'h02) begin
            miscompares++; $display("FAIL load_next: got adr=%0d leds=%h want 3 02", ADR, LEDS);
        end
    endtask

    task automatic test_clear_priority();
        LOAD_PAT = 1'b1; cyc(); LOAD_PAT = 1'b0;
        vectors++;
        if (LEDS !== 8'h04) begin
            miscompares++; $display("FAIL clr_setup: got %h want 04", LEDS);
        end
        CLEAR = 1'b1; NXT_ADR = 1'b1; LOAD_PAT = 1'b1; cyc();
        CLEAR = 1'b0; NXT_ADR = 1'b0; LOAD_PAT = 1'b0;
        vectors++;
        if (ADR !== 5'd0 || LEDS !== 8'h00 || DONE !== 1'b0 || dut.pat_q0 !== 8'h00) begin
            miscompares++; $display("FAIL clr_prio: got adr=%0d leds=%h done=%b want 0 00 0", ADR, LEDS, DONE);
        end
    endtask

    task automatic test_disp();
        NXT_ADR = 1'b1; repeat (5) cyc(); NXT_ADR = 1'b0;
        LOAD_PAT = 1'b1; cyc(); LOAD_PAT = 1'b0;
        vectors++;
        if (LEDS !== 8'h10 || ADR !== 5'd5) begin
            miscompares++; $display("FAIL disp_on: got leds=%h adr=%0d want 10 5", LEDS, ADR);
        end
        DISP = 1'b0; #1;
        vectors++;
        if (LEDS !== 8'h10) begin
            miscompares++; $display("FAIL disp_latency: got %h want 10", LEDS);
        end
        cyc();
        vectors++;
        if (LEDS !== 8'h00) begin
            miscompares++; $display("FAIL disp_off: got %h want 00", LEDS);
        end
        DISP = 1'b1; cyc();
        vectors++;
        if (LEDS !== 8'h10) begin
            miscompares++; $display("FAIL disp_reon: got %h want 10", LEDS);
        end
    endtask

    task automatic test_upset();
        RST_TIMER = 1'b0; repeat (3) cyc();
        force dut.adr_q1 = 5'd17;
        force dut.timer_q2 = 16'h1234;
        #1;
        vectors++;
        if (ADR !== 5'd5 || TIMER !== 16'd3 || DONE !== 1'b0) begin
            miscompares++; $display("FAIL upset_mask: got adr=%0d timer=%0d done=%b want 5 3 0", ADR, TIMER, DONE);
        end
        release dut.adr_q1;
        release dut.timer_q2;
        cyc();
        vectors++;
        if (dut.adr_q1 !== 5'd5 || dut.timer_q2 !== 16'd4 || ADR !== 5'd5 || TIMER !== 16'd4) begin
            miscompares++;
            $display("FAIL upset_scrub: got adr_q1=%0d timer_q2=%0d adr=%0d timer=%0d want 5 4 5 4", dut.adr_q1, dut.timer_q2, ADR, TIMER);
        end
    endtask

    task automatic test_async_reset();
        #2 RST_N = 1'b0;
        #1;
        vectors++;
        if ({TIMER, ADR, DONE, LEDS} !== 30'd0) begin
            miscompares++;
            $display("FAIL async_rst: got timer=%h adr=%h done=%b leds=%h want all 0", TIMER, ADR, DONE, LEDS);
        end
        @(negedge CLK);
        RST_N = 1'b1; NXT_ADR = 1'b1; RST_TIMER = 1'b0;
        cyc();
        NXT_ADR = 1'b0;
        vectors++;
        if (ADR !== 5'd1 || TIMER !== 16'd1 || LEDS !== 8'h00) begin
            miscompares++; $display("FAIL rst_release: got adr=%0d timer=%0d leds=%h want 1 1 00", ADR, TIMER, LEDS);
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_sequence();
        test_load_with_next();
        test_clear_priority();
        test_disp();
        test_upset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
